// File: rtl/if_fetch_sequencer.sv
// rtl/if_fetch_sequencer.sv - instruction-fetch sequencer: PC, imem addressing, in-order fetch queue
// Optional: FETCH_MISALIGN_TRAP_EN adds misalign_err output and an ERR trap state.
module if_fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] END_PC   = 32'h0000_0014,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        halted,
    output logic        busy
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        misalign_err
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HALT
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        S_ERR
`endif
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     inst_mem_q [DEPTH];
    logic [31:0]     pc_mem_q   [DEPTH];
    logic            push, pop, flush;
    logic            pop_req, redirect_ok;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic            merr_q, merr_d;
`endif

    assign pop_req     = (count_q != '0) && out_ready;
    assign redirect_ok = redirect_valid && ((state_q == S_FETCH) || (state_q == S_HALT));

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;
        pop     = 1'b0;
        flush   = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        merr_d  = merr_q;
`endif
        if (redirect_ok) begin
            // Redirect wins over any push/pop in the same cycle.
            flush = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
            pc_d = redirect_pc;
            if (redirect_pc[1:0] != 2'b00) begin
                state_d = S_ERR;
                merr_d  = 1'b1;
            end else begin
                state_d = S_FETCH;
            end
`else
            pc_d    = redirect_pc & ~32'h3;
            state_d = S_FETCH;
`endif
        end else begin
            pop = pop_req;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_FETCH;
                        pc_d    = RESET_PC;
                    end
                end
                S_FETCH: begin
                    if (pc_q >= END_PC) begin
                        state_d = S_HALT;
                    end else if ((count_q < CW'(DEPTH)) || pop_req) begin
                        push = 1'b1;
                        pc_d = pc_q + 32'd4;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            merr_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            merr_q   <= merr_d;
`endif
        end
    end

    // Queue storage needs no reset: count gates visibility of every slot.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem_q[wr_ptr_q] <= imem_data;
            pc_mem_q[wr_ptr_q]   <= pc_q;
        end
    end

    assign imem_addr = pc_q;
    assign out_valid = (count_q != '0);
    assign out_inst  = out_valid ? inst_mem_q[rd_ptr_q] : 32'h0;
    assign out_pc    = out_valid ? pc_mem_q[rd_ptr_q]   : 32'h0;
    assign busy      = (state_q == S_FETCH) || (count_q != '0);
`ifdef FETCH_MISALIGN_TRAP_EN
    assign halted       = (state_q == S_HALT) || (state_q == S_ERR);
    assign misalign_err = merr_q;
`else
    assign halted    = (state_q == S_HALT);
`endif

endmodule

// File: tb/tb_if_fetch_sequencer.sv
// tb/tb_if_fetch_sequencer.sv - self-checking bench for if_fetch_sequencer with queue-based reference model
module tb_if_fetch_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] END_PC   = 32'h14;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        halted;
    logic        busy;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign_err;
`endif

    always #5 clk = ~clk;

    if_fetch_sequencer #(.RESET_PC(RESET_PC), .END_PC(END_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_pc(out_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halted(halted), .busy(busy)
`ifdef FETCH_MISALIGN_TRAP_EN
        , .misalign_err(misalign_err)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'd0:   return 32'h8C22000A;
            32'd4:   return 32'hAC230005;
            32'd8:   return 32'h00A31025;
            32'd12:  return 32'h00C70825;
            32'd16:  return 32'h3061000A;
            default: return (a * 32'h9E3779B1) ^ 32'h0000_1234;
        endcase
    endfunction

    assign imem_data = mem_word(imem_addr);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain queue of fetched {pc, inst}; states 0=idle 1=fetch 2=halt 3=err
    logic [31:0] mq_pc[$];
    logic [31:0] mq_inst[$];
    logic [31:0] m_pc;
    int          m_state;
    bit          m_err;
    bit          m_ok = 1'b0;
    bit          m_pop;
    logic [31:0] popped[$];

    initial forever begin
        @(negedge clk);
        if (m_ok) begin
            chk("imem_addr", imem_addr, m_pc);
            chk("out_valid", 32'(out_valid), 32'(mq_pc.size() != 0));
            if (mq_pc.size() != 0) begin
                chk("out_pc", out_pc, mq_pc[0]);
                chk("out_inst", out_inst, mq_inst[0]);
            end else begin
                chk("out_pc_empty", out_pc, 32'h0);
                chk("out_inst_empty", out_inst, 32'h0);
            end
            chk("halted", 32'(halted), 32'(m_state == 2 || m_state == 3));
            chk("busy", 32'(busy), 32'(m_state == 1 || mq_pc.size() != 0));
`ifdef FETCH_MISALIGN_TRAP_EN
            chk("misalign_err", 32'(misalign_err), 32'(m_err));
`endif
        end
        if (rst && out_valid && out_ready && !redirect_valid) popped.push_back(out_pc);
        // Advance the model using the inputs that the next rising edge will sample.
        if (!rst) begin
            mq_pc.delete();
            mq_inst.delete();
            m_pc    = RESET_PC;
            m_state = 0;
            m_err   = 1'b0;
            m_ok    = 1'b1;
        end else if (m_ok) begin
            m_pop = (mq_pc.size() != 0) && out_ready;
            if (redirect_valid && (m_state == 1 || m_state == 2)) begin
                mq_pc.delete();
                mq_inst.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
                m_pc = redirect_pc;
                if (redirect_pc % 4 != 0) begin
                    m_state = 3;
                    m_err   = 1'b1;
                end else begin
                    m_state = 1;
                end
`else
                m_pc    = redirect_pc - (redirect_pc % 4);
                m_state = 1;
`endif
            end else begin
                if (m_pop) begin
                    void'(mq_pc.pop_front());
                    void'(mq_inst.pop_front());
                end
                if (m_state == 0 && start) begin
                    m_state = 1;
                    m_pc    = RESET_PC;
                end else if (m_state == 1) begin
                    if (m_pc >= END_PC) begin
                        m_state = 2;
                    end else if (mq_pc.size() < DEPTH) begin
                        mq_pc.push_back(m_pc);
                        mq_inst.push_back(mem_word(m_pc));
                        m_pc = m_pc + 32'd4;
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset_start(input logic ready);
        rst = 1'b0; start = 1'b0; redirect_valid = 1'b0; out_ready = ready;
        cyc(); cyc();
        rst = 1'b1; start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    logic [31:0] exp_pc   [5] = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd16};
    logic [31:0] exp_inst [5] = '{32'h8C22000A, 32'hAC230005, 32'h00A31025, 32'h00C70825, 32'h3061000A};
    logic [31:0] held_addr;

    initial begin
        // Reset state
        cyc(); cyc();
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_imem_addr", imem_addr, 32'h0);

        // Straight-line program, ready held high
        do_reset_start(1'b1);
        popped.delete();
        repeat (10) cyc();
        chk("run_pop_count", 32'(popped.size()), 32'd5);
        for (int i = 0; i < 5 && i < popped.size(); i++) chk("run_pop_pc", popped[i], exp_pc[i]);
        chk("run_halted", 32'(halted), 32'h1);
        chk("run_out_valid", 32'(out_valid), 32'h0);

        // Back-pressure: queue fills, pc holds, head stable
        do_reset_start(1'b0);
        repeat (4) cyc();
        chk("stall_out_pc", out_pc, 32'h0);
        chk("stall_out_inst", out_inst, exp_inst[0]);
        chk("stall_imem_addr", imem_addr, 32'h8);
        popped.delete();
        out_ready = 1'b1;
        repeat (8) cyc();
        chk("drain_pop_count", 32'(popped.size()), 32'd5);
        for (int i = 0; i < 5 && i < popped.size(); i++) chk("drain_pop_pc", popped[i], exp_pc[i]);

        // Redirect concurrent with a pop on a full queue
        do_reset_start(1'b0);
        repeat (4) cyc();
        popped.delete();
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h4;
        cyc();
        redirect_valid = 1'b0;
        chk("redir_flush_valid", 32'(out_valid), 32'h0);
        chk("redir_imem_addr", imem_addr, 32'h4);
        cyc();
        chk("redir_first_pc", out_pc, 32'h4);
        repeat (6) cyc();
        chk("redir_pop_count", 32'(popped.size()), 32'd4);
        if (popped.size() != 0) chk("redir_pop_first", popped[0], 32'h4);

        // Redirect out of HALT
        chk("pre_halt", 32'(halted), 32'h1);
        popped.delete();
        redirect_valid = 1'b1; redirect_pc = 32'h8;
        cyc();
        redirect_valid = 1'b0;
        chk("unhalt", 32'(halted), 32'h0);
        repeat (6) cyc();
        chk("rehalt_pop_count", 32'(popped.size()), 32'd3);
        for (int i = 0; i < 3 && i < popped.size(); i++) chk("rehalt_pop_pc", popped[i], exp_pc[i + 2]);
        chk("rehalt", 32'(halted), 32'h1);

        // Reset in the middle of fetching with entries queued
        do_reset_start(1'b0);
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        chk("midrst_out_valid", 32'(out_valid), 32'h0);
        chk("midrst_imem_addr", imem_addr, 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        rst = 1'b1; start = 1'b1; out_ready = 1'b1;
        popped.delete();
        cyc();
        start = 1'b0;
        repeat (3) cyc();
        if (popped.size() != 0) chk("midrst_resume_pc", popped[0], 32'h0);
        else chk("midrst_resume_count", 32'(popped.size()), 32'd1);

        // Misaligned redirect
        do_reset_start(1'b1);
        repeat (2) cyc();
        popped.delete();
        redirect_valid = 1'b1; redirect_pc = 32'h6;
        cyc();
        redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis_err", 32'(misalign_err), 32'h1);
        chk("mis_halted", 32'(halted), 32'h1);
        chk("mis_out_valid", 32'(out_valid), 32'h0);
        held_addr = imem_addr;
        repeat (3) cyc();
        chk("mis_addr_frozen", imem_addr, held_addr);
`else
        repeat (3) cyc();
        held_addr = (popped.size() != 0) ? popped[0] : 32'hFFFF_FFFF;
        chk("mis_aligned_pc", held_addr, 32'h4);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst            = ($urandom % 97) != 0;
            start          = ($urandom % 8) == 0;
            out_ready      = ($urandom % 4) != 0;
            redirect_valid = ($urandom % 16) == 0;
            redirect_pc    = $urandom_range(0, 27);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
